seq_bit_serializer: RTL

//  Parallel-to-serial stimulus feeder sitting directly upstream of the sequence

---
 rtl/seq_bit_serializer.sv | 109 ++++++++++
 1 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: first bit is on ip the cycle after accept,
// and back-to-back words form a gapless stream. stall freezes the shift and drops ip_valid.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [$clog2(WIDTH+1)-1:0]   in_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         stall,
  output logic                         ip,
  output logic                         ip_valid,
  output logic                         frame_done,
  output logic                         len_err,
  output logic                         busy
);

  localparam int LW = $clog2(WIDTH+1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LW-1:0]    bits_left;
  logic [LW-1:0]    len_c;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] aligned;
  logic             accept;
  logic             load;
  logic             advance;
  logic             last_out;

  assign len_c   = (in_len > LW'(WIDTH)) ? LW'(WIDTH) : in_len;
  // For MSB-first, left-justify the active bits so the next bit is always the top one.
  assign aligned = in_data << (LW'(WIDTH) - len_c);

  assign accept   = in_valid && in_ready;
  assign load     = accept && (len_c != '0);
  assign advance  = (state == SHIFT) && !stall && (bits_left > LW'(1));
  assign last_out = (state == SHIFT) && (state_nxt == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    ip_valid   = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && (len_c != '0)) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        ip_valid = !stall;
        if (!stall && (bits_left == LW'(1))) begin
          in_ready   = 1'b1;
          frame_done = 1'b1;
          if (!(in_valid && (len_c != '0))) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ip is registered; a stalled cycle simply skips the update so the bit is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      bits_left <= '0;
      ip        <= IDLE_BIT;
      len_err   <= 1'b0;
    end else begin
      len_err <= accept && (len_c == '0);
      if (load) begin
        bits_left <= len_c;
        ip        <= MSB_FIRST ? aligned[WIDTH-1] : in_data[0];
        shreg     <= MSB_FIRST ? (aligned << 1) : (in_data >> 1);
      end else if (advance) begin
        bits_left <= bits_left - LW'(1);
        ip        <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        shreg     <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      end else if (last_out) begin
        bits_left <= '0;
        ip        <= IDLE_BIT;
      end
    end
  end

endmodule
